// File: rtl/rom_stream_pkg.sv
// Shared constants and state encoding for the ROM stream reader.
// Optional feature macro used by the top: ROM_STREAM_CHECKSUM_EN.
package rom_stream_pkg;

  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_DEPTH    = 6801;
  // Outstanding words (buffered + in flight) the reader may hold at once.
  localparam int CREDIT_LIMIT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_stream_fifo2.sv
// Two-entry shift buffer: slot0 is always the head, so the head word holds
// its value after the buffer empties. Flush empties without touching data.
module rom_stream_fifo2 #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slot0_q;
  logic [W-1:0] slot1_q;
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'd2) || do_pop);

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values. The data slots are reset too, because the head drives a
  // port whose reset value is defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= wdata;
          else                 slot1_q <= wdata;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_q <= slot1_q;
            slot1_q <= wdata;
          end else begin
            slot0_q <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = slot0_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/rom_stream_reader.sv
// Walks a wrapping ROM address range and streams the words out valid/ready.
// Define ROM_STREAM_CHECKSUM_EN to add a running sum of accepted words.
module rom_stream_reader
  import rom_stream_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
`ifdef ROM_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] to_issue_q;
  logic              inflight_q;
  logic              inflight_last_q;
  logic              accept_start;
  logic              pop;
  logic              issue;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        occupancy;
  logic [2:0]        credits_used;
  logic [DATA_W:0]   head;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

  assign accept_start = (state_q == IDLE) && start && !abort;
  assign pop          = m_valid && m_ready;

  // The accepted start issues the first read itself, so the base address goes
  // straight to the ROM that cycle; later reads come from the address counter.
  assign rom_addr = accept_start ? base_addr : addr_q;

  // Counting this cycle's pop as a freed credit is what sustains 1 word/cycle.
  assign occupancy    = {fifo_full, !fifo_empty && !fifo_full};
  assign credits_used = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue        = (state_q == RUN) && (to_issue_q != '0)
                        && (credits_used < 3'(CREDIT_LIMIT));

  rom_stream_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (inflight_q),
    .pop   (pop),
    .wdata ({inflight_last_q, rom_data}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign m_valid          = !fifo_empty;
  assign {m_last, m_data} = head;
  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);

  // NOTE: combinational logic uses blocking '=' and assigns a default first,
  // so no path leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept_start) state_d = RUN;
      // An empty burst passes through RUN for one busy cycle before DONE.
      RUN: begin
        if (to_issue_q == '0)
          state_d = (fifo_empty && !inflight_q) ? DONE : DRAIN;
        else if (issue && (to_issue_q == ADDR_W'(1)))
          state_d = DRAIN;
      end
      DRAIN: if (pop && m_last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      to_issue_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= !abort && (issue || (accept_start && (word_count != '0)));
      if (abort) begin
        to_issue_q <= '0;
      end else if (accept_start) begin
        addr_q          <= next_addr(base_addr);
        to_issue_q      <= (word_count == '0) ? '0 : word_count - ADDR_W'(1);
        inflight_last_q <= (word_count == ADDR_W'(1));
      end else if (issue) begin
        addr_q          <= next_addr(addr_q);
        to_issue_q      <= to_issue_q - ADDR_W'(1);
        inflight_last_q <= (to_issue_q == ADDR_W'(1));
      end
    end
  end

`ifdef ROM_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     checksum <= '0;
    else if (abort || accept_start) checksum <= '0;
    else if (pop)                   checksum <= checksum + m_data;
  end
`endif

endmodule
